point_add_arbiter: RTL

//  Shares one elliptic-curve point-add unit (add) between NUM_REQ requesters (scalar-mult engines).

---
 rtl/ecc_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/point_add_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared types for the EC point-add arbiter slice.
// Exports the FSM state enum and the default coordinate width.
package ecc_pkg;

  localparam int DATA_WIDTH_DEF = 192;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports: req (pending lines), ptr (last winner) -> gnt (one-hot), idx, any.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Search starts just after the last winner, so it drops to lowest priority.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/point_add_arbiter.sv
// Shares one EC point-add unit between NUM_REQ requesters, round-robin.
// Ports: req_* (requesters), resp_* (results), add_* (add unit), busy.
module point_add_arbiter
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_REQ    = 2,
  parameter int TIMEOUT    = 1023
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Px,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Py,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Qx,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_Qy,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic                          resp_err,
  output logic [DATA_WIDTH-1:0]         resp_Rx,
  output logic [DATA_WIDTH-1:0]         resp_Ry,
  output logic [DATA_WIDTH-1:0]         add_Px,
  output logic [DATA_WIDTH-1:0]         add_Py,
  output logic [DATA_WIDTH-1:0]         add_Qx,
  output logic [DATA_WIDTH-1:0]         add_Qy,
  output logic                          add_in_valid,
  input  logic [DATA_WIDTH-1:0]         add_Rx,
  input  logic [DATA_WIDTH-1:0]         add_Ry,
  input  logic                          add_out_valid,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int DW = DATA_WIDTH;

  state_t        state, state_n;
  logic [IW-1:0] owner;
  logic [IW-1:0] ptr;
  logic [WW-1:0] wd;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] gidx;
  logic          gany;
  logic          wd_hit;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (gany)
  );

  assign wd_hit = (wd == WW'(TIMEOUT));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (gany) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (add_out_valid || wd_hit) state_n = RESP;
      RESP:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= IW'(NUM_REQ - 1);
      wd       <= '0;
      add_Px   <= '0;
      add_Py   <= '0;
      add_Qx   <= '0;
      add_Qy   <= '0;
      resp_Rx  <= '0;
      resp_Ry  <= '0;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (gany) begin
            add_Px <= req_Px[gidx*DW +: DW];
            add_Py <= req_Py[gidx*DW +: DW];
            add_Qx <= req_Qx[gidx*DW +: DW];
            add_Qy <= req_Qy[gidx*DW +: DW];
            owner  <= gidx;
            ptr    <= gidx;
          end
        end
        ISSUE: wd <= '0;
        WAIT: begin
          // A result landing on the expiry cycle still counts as good.
          if (add_out_valid) begin
            resp_Rx  <= add_Rx;
            resp_Ry  <= add_Ry;
            resp_err <= 1'b0;
          end else if (wd_hit) begin
            resp_Rx  <= '0;
            resp_Ry  <= '0;
            resp_err <= 1'b1;
          end else begin
            wd <= wd + WW'(1);
          end
        end
        RESP: begin
          add_Px <= '0;
          add_Py <= '0;
          add_Qx <= '0;
          add_Qy <= '0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready    = (rst_n && state == IDLE) ? gnt : '0;
  assign add_in_valid = (state == ISSUE);
  assign busy         = (state != IDLE);

  always_comb begin
    resp_valid = '0;
    if (state == RESP) resp_valid[owner] = 1'b1;
  end

endmodule
